// File: rtl/path_player.sv
// rtl/path_player.sv - replays a solved maze path from the path stack to a valid/ready consumer
module path_player #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] stckCnt,
    output logic              rdEn,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [1:0]        rdData,
    output logic [1:0]        dirOut,
    output logic [7:0]        locOut,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WAIT,
        S_SHOW,
        S_FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        dir_q;
    logic [7:0]        loc_q;
    logic              last_step;

    // Row and column are independent 4-bit fields; a wrap in one never touches the other.
    function automatic logic [7:0] step_loc(input logic [7:0] loc, input logic [1:0] d);
        logic [3:0] row;
        logic [3:0] col;
        row = loc[7:4];
        col = loc[3:0];
        case (d)
            2'b00:   col = col + 4'd1;
            2'b01:   row = row + 4'd1;
            2'b10:   col = col - 4'd1;
            default: row = row - 4'd1;
        endcase
        return {row, col};
    endfunction

    assign idx_inc   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign last_step = (idx_inc == len_q);

    // The read address follows idx while reading and otherwise holds the last address issued.
    assign rdAddr = (state == S_READ) ? idx_q : rd_addr_q;
    assign dirOut = dir_q;
    assign locOut = loc_q;

    // State register; reset returns to IDLE from anywhere without issuing done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded strobes; valid is a pure function of state, never of ready.
    always_comb begin
        state_next = state;
        rdEn       = 1'b0;
        valid      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = (len_q == '0) ? S_FIN : S_READ;
            end
            S_READ: begin
                rdEn       = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                state_next = S_SHOW;
            end
            S_SHOW: begin
                valid = 1'b1;
                if (ready) begin
                    state_next = last_step ? S_FIN : S_READ;
                end
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Path length, step index, read address, direction and location registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            dir_q     <= 2'b00;
            loc_q     <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= stckCnt;
                    end
                end
                S_LOAD: begin
                    idx_q <= '0;
                    loc_q <= 8'h00;
                end
                S_READ: begin
                    rd_addr_q <= idx_q;
                end
                S_WAIT: begin
                    dir_q <= rdData;
                    loc_q <= step_loc(loc_q, rdData);
                end
                S_SHOW: begin
                    if (ready) begin
                        idx_q <= idx_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
